// File: rtl/serial_subtractor_16bits.sv
// Digit-serial subtractor: OUT = IN1 - IN2 (mod 2^WIDTH), one DIGIT_W slice per clock,
// LSB first, with START/BUSY/DONE handshake and borrow/overflow/zero flags.
module serial_subtractor_16bits #(
   parameter int WIDTH   = 16,
   parameter int DIGIT_W = 4
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             START,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   output logic [WIDTH-1:0] OUT,
   output logic             BORROW,
   output logic             OVF,
   output logic             ZERO,
   output logic             BUSY,
   output logic             DONE
);

   localparam int N     = WIDTH / DIGIT_W;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit
      $error("serial_subtractor_16bits: WIDTH must be a multiple of DIGIT_W");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [WIDTH-1:0]   a_r, a_s;
   logic [WIDTH-1:0]   b_r, b_s;
   logic [WIDTH-1:0]   res_r, res_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic               borrow_r, borrow_s;
   logic               msb1_r, msb1_s;
   logic               msb2_r, msb2_s;
   logic [WIDTH-1:0]   out_r, out_s;
   logic               borrow_out_r, borrow_out_s;
   logic               ovf_r, ovf_s;
   logic               zero_r, zero_s;
   logic               busy_r, busy_s;
   logic               done_r, done_s;

   logic [DIGIT_W:0]   slice_s;
   logic [WIDTH-1:0]   res_shift_s;

   // Slice arithmetic: the top bit of the (DIGIT_W+1)-bit difference is the outgoing borrow.
   always_comb begin
      slice_s = {1'b0, a_r[DIGIT_W-1:0]} - {1'b0, b_r[DIGIT_W-1:0]}
              - {{DIGIT_W{1'b0}}, borrow_r};
      res_shift_s = (res_r >> DIGIT_W)
                  | (WIDTH'(slice_s[DIGIT_W-1:0]) << (WIDTH - DIGIT_W));
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_s      = state_r;
      a_s          = a_r;
      b_s          = b_r;
      res_s        = res_r;
      cnt_s        = cnt_r;
      borrow_s     = borrow_r;
      msb1_s       = msb1_r;
      msb2_s       = msb2_r;
      out_s        = out_r;
      borrow_out_s = borrow_out_r;
      ovf_s        = ovf_r;
      zero_s       = zero_r;
      busy_s       = busy_r;
      done_s       = done_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               a_s      = IN1;
               b_s      = IN2;
               msb1_s   = IN1[WIDTH-1];
               msb2_s   = IN2[WIDTH-1];
               cnt_s    = {CNT_W{1'b0}};
               borrow_s = 1'b0;
               busy_s   = 1'b1;
               done_s   = 1'b0;
               state_s  = ST_RUN;
            end else begin
               state_s  = state_r;
            end
         end
         ST_RUN: begin
            res_s    = res_shift_s;
            borrow_s = slice_s[DIGIT_W];
            a_s      = a_r >> DIGIT_W;
            b_s      = b_r >> DIGIT_W;
            if (cnt_r == CNT_W'(N - 1)) begin
               // Overflow only possible when operand signs differ.
               out_s        = res_shift_s;
               borrow_out_s = slice_s[DIGIT_W];
               ovf_s        = (msb1_r != msb2_r) && (res_shift_s[WIDTH-1] != msb1_r);
               zero_s       = (res_shift_s == {WIDTH{1'b0}});
               busy_s       = 1'b0;
               done_s       = 1'b1;
               cnt_s        = {CNT_W{1'b0}};
               state_s      = ST_DONE;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            busy_s  = 1'b0;
            done_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; asynchronous reset discards any partial result.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_r      <= ST_IDLE;
         a_r          <= {WIDTH{1'b0}};
         b_r          <= {WIDTH{1'b0}};
         res_r        <= {WIDTH{1'b0}};
         cnt_r        <= {CNT_W{1'b0}};
         borrow_r     <= 1'b0;
         msb1_r       <= 1'b0;
         msb2_r       <= 1'b0;
         out_r        <= {WIDTH{1'b0}};
         borrow_out_r <= 1'b0;
         ovf_r        <= 1'b0;
         zero_r       <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         a_r          <= a_s;
         b_r          <= b_s;
         res_r        <= res_s;
         cnt_r        <= cnt_s;
         borrow_r     <= borrow_s;
         msb1_r       <= msb1_s;
         msb2_r       <= msb2_s;
         out_r        <= out_s;
         borrow_out_r <= borrow_out_s;
         ovf_r        <= ovf_s;
         zero_r       <= zero_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
      end
   end

   assign OUT    = out_r;
   assign BORROW = borrow_out_r;
   assign OVF    = ovf_r;
   assign ZERO   = zero_r;
   assign BUSY   = busy_r;
   assign DONE   = done_r;

endmodule
